// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3), one
// input bit per clock. Sits behind the divider and feeds the display path.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready upstream handshake; a word is taken only in IDLE
//   bin               unsigned binary operand (WIDTH bits)
//   out_valid/out_ready downstream handshake; result held until taken
//   bcd               packed BCD, units digit in [3:0]
//   busy              high while converting or holding a result
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    localparam int AW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    sr_q, sr_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       bcd_q, bcd_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [AW-1:0]       acc_adj;
    logic [AW+WIDTH-1:0] shift_v;

    // Digit correction happens on the pre-shift value, all digits in parallel.
    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                          : acc_q[4*i +: 4];
        end
        // Binary MSB moves into accumulator bit 0; accumulator overflow is dropped.
        shift_v = {acc_adj, sr_q} << 1;
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = shift_v[AW+WIDTH-1:WIDTH];
                sr_d  = shift_v[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Result register is only loaded here, so bcd never shows
                    // a partial conversion and keeps its value through IDLE.
                    bcd_d       = shift_v[AW+WIDTH-1:WIDTH];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Depends on registered state only; held low while reset is applied.
    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bin;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] bcd;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    logic [19:0] exp_q[$];

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r = '0;
        int x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Scoreboard: pop and compare whenever a result is handed off.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [19:0] e;
            logic        ok;
            ok = 1'b1;
            for (int i = 0; i < 5; i++) if (bcd[4*i +: 4] > 4'd9) ok = 1'b0;
            chk("digits_le9", {31'd0, ok}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("bcd", {12'd0, bcd}, {12'd0, e});
            end
        end
    end

    // Called just after a rising edge. Leaves in_valid as-is if keep is set.
    task automatic do_conv(input logic [15:0] b, input bit keep, output int lat);
        int w;
        in_valid = 1'b1;
        bin      = b;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        exp_q.push_back(to_bcd(int'(b)));
        #1;
        if (!keep) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int sweep[6] = '{9, 10, 99, 100, 9999, 10000};

        rst = 1'b1; in_valid = 1'b0; bin = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bcd", {12'd0, bcd}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic conversion and latency
        do_conv(16'd1234, 1'b0, lat);
        chk("lat_1234", lat, 16);
        @(posedge clk); #1;
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("bcd_hold_idle", {12'd0, bcd}, 32'h01234);

        do_conv(16'd65535, 1'b0, lat);
        chk("lat_max", lat, 16);
        @(posedge clk); #1;
        do_conv(16'd0, 1'b0, lat);
        chk("lat_zero", lat, 16);
        @(posedge clk); #1;

        foreach (sweep[k]) begin
            do_conv(16'(sweep[k]), 1'b0, lat);
            @(posedge clk); #1;
        end

        // Backpressure
        out_ready = 1'b0;
        do_conv(16'd4321, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_bcd", {12'd0, bcd}, 32'h04321);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

        // in_valid held high, bin changes mid-conversion: ignored until IDLE
        do_conv(16'd4321, 1'b1, lat);
        chk("hold_lat", lat, 16);
        @(posedge clk); #1;
        do_conv(16'd777, 1'b0, lat);
        @(posedge clk); #1;

        // Overwrite bin during SHIFT explicitly
        in_valid = 1'b1; bin = 16'd4321;
        @(posedge clk); #1;
        exp_q.push_back(to_bcd(4321));
        chk("mid_busy", {31'd0, busy}, 32'd1);
        bin = 16'd777;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("mid_lat", lat, 16);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset at iteration 7 of 50000
        in_valid = 1'b1; bin = 16'd50000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bcd", {12'd0, bcd}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        do_conv(16'd50000, 1'b0, lat);
        chk("lat_50000", lat, 16);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
